// File: rtl/fusion_decode_pkg.sv
// fusion_decode_pkg: shared encodings for the decode pipeline stage
// Contents: register-tag address constants, ctrl bit positions, FSM state
// encoding, opcode and ALU-operation encodings, tag liveness helper.
// Instruction layout (all formats share op/bank/rd/rs1):
//   [31:28] op  [27:25] bank  [24:20] rd  [19:15] rs1  [14:10] rs2
//   R-type funct in [3:0]; I-type imm15 [14:0]; S/B-type imm10 [9:0];
//   JAL/LUI imm20 [19:0]. The bank field applies to every register of the insn.
package fusion_decode_pkg;

   localparam int ADDR_W = 5;
   localparam logic [ADDR_W-1:0] TAG_ADDR_ZERO = '0;

   localparam int CTRL_W         = 7;
   localparam int CTRL_PC_REL    = 0;
   localparam int CTRL_PC_ABS    = 1;
   localparam int CTRL_LINK      = 2;
   localparam int CTRL_MEM_READ  = 3;
   localparam int CTRL_MEM_WRITE = 4;
   localparam int CTRL_SYSCALL   = 5;
   localparam int CTRL_MEMSYNC   = 6;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HAZARD = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   localparam logic [3:0] OP_R      = 4'h0;
   localparam logic [3:0] OP_ADDI   = 4'h1;
   localparam logic [3:0] OP_LOAD   = 4'h2;
   localparam logic [3:0] OP_STORE  = 4'h3;
   localparam logic [3:0] OP_BRANCH = 4'h4;
   localparam logic [3:0] OP_JAL    = 4'h5;
   localparam logic [3:0] OP_JALR   = 4'h6;
   localparam logic [3:0] OP_LUI    = 4'h7;
   localparam logic [3:0] OP_SYS    = 4'h8;
   localparam logic [3:0] OP_SYNC   = 4'h9;

   localparam logic [3:0] ALU_ADD   = 4'h0;
   localparam logic [3:0] ALU_SUB   = 4'h1;
   localparam logic [3:0] ALU_AND   = 4'h2;
   localparam logic [3:0] ALU_OR    = 4'h3;
   localparam logic [3:0] ALU_XOR   = 4'h4;
   localparam logic [3:0] ALU_SLL   = 4'h5;
   localparam logic [3:0] ALU_SRL   = 4'h6;
   localparam logic [3:0] ALU_SRA   = 4'h7;
   localparam logic [3:0] ALU_SLT   = 4'h8;
   localparam logic [3:0] ALU_SLTU  = 4'h9;
   localparam logic [3:0] ALU_PASSB = 4'hA;

   // Address 0 is the hardwired zero register: never written, never matched.
   function automatic logic addr_live(input logic [ADDR_W-1:0] addr);
      return addr != TAG_ADDR_ZERO;
   endfunction

endpackage

// File: rtl/decode_pipe_stage_if.sv
// decode_pipe_stage_if: fetch-to-decode handshake
// Signals: valid_in/insn_in/insn_pc_in/flush_in driven by fetch (master),
// ready_out driven by the decode stage (slave).
interface decode_pipe_stage_if #(
   parameter int XLEN = 32
);
   logic            valid_in;
   logic [31:0]     insn_in;
   logic [XLEN-1:0] insn_pc_in;
   logic            flush_in;
   logic            ready_out;

   modport master (output valid_in, insn_in, insn_pc_in, flush_in, input ready_out);
   modport slave  (input valid_in, insn_in, insn_pc_in, flush_in, output ready_out);
endinterface

// File: rtl/decode_fields.sv
// decode_fields: combinational field extraction of one instruction word
// Ports: insn (in) -> rsa_tag/rsb_tag (source tags, 0 when unused),
// rd_tag (destination, 0 when none), imm (sign-extended), aluop, ctrl.
module decode_fields
   import fusion_decode_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int BANK_W = 3,
   parameter int TAG_W  = BANK_W + 5
) (
   input  logic [31:0]       insn,
   output logic [TAG_W-1:0]  rsa_tag,
   output logic [TAG_W-1:0]  rsb_tag,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [XLEN-1:0]   imm,
   output logic [3:0]        aluop,
   output logic [CTRL_W-1:0] ctrl
);

   logic [3:0]        op;
   logic [BANK_W-1:0] bank;
   logic              use_a, use_b, use_d;

   assign op   = insn[31:28];
   assign bank = BANK_W'(insn[27:25]);

   always_comb begin
      use_a = 1'b0;
      use_b = 1'b0;
      use_d = 1'b0;
      imm   = '0;
      aluop = ALU_ADD;
      ctrl  = '0;
      case (op)
         OP_R: begin
            use_a = 1'b1;
            use_b = 1'b1;
            use_d = 1'b1;
            aluop = insn[3:0];
         end
         OP_ADDI: begin
            use_a = 1'b1;
            use_d = 1'b1;
            imm   = XLEN'($signed(insn[14:0]));
         end
         OP_LOAD: begin
            use_a = 1'b1;
            use_d = 1'b1;
            imm   = XLEN'($signed(insn[14:0]));
            ctrl[CTRL_MEM_READ] = 1'b1;
         end
         OP_STORE: begin
            use_a = 1'b1;
            use_b = 1'b1;
            imm   = XLEN'($signed(insn[9:0]));
            ctrl[CTRL_MEM_WRITE] = 1'b1;
         end
         OP_BRANCH: begin
            use_a = 1'b1;
            use_b = 1'b1;
            imm   = XLEN'($signed(insn[9:0]));
            aluop = ALU_SUB;
            ctrl[CTRL_PC_REL] = 1'b1;
         end
         OP_JAL: begin
            use_d = 1'b1;
            imm   = XLEN'($signed(insn[19:0]));
            ctrl[CTRL_PC_REL] = 1'b1;
            ctrl[CTRL_LINK]   = 1'b1;
         end
         OP_JALR: begin
            use_a = 1'b1;
            use_d = 1'b1;
            imm   = XLEN'($signed(insn[14:0]));
            ctrl[CTRL_PC_ABS] = 1'b1;
            ctrl[CTRL_LINK]   = 1'b1;
         end
         OP_LUI: begin
            use_d = 1'b1;
            imm   = XLEN'({insn[19:0], 12'd0});
            aluop = ALU_PASSB;
         end
         OP_SYS:  ctrl[CTRL_SYSCALL] = 1'b1;
         OP_SYNC: ctrl[CTRL_MEMSYNC] = 1'b1;
         default: ;
      endcase
   end

   assign rsa_tag = use_a ? TAG_W'({bank, insn[19:15]}) : '0;
   assign rsb_tag = use_b ? TAG_W'({bank, insn[14:10]}) : '0;
   assign rd_tag  = use_d ? TAG_W'({bank, insn[24:20]}) : '0;

endmodule

// File: rtl/decode_pipe_stage.sv
// decode_pipe_stage: instruction decode with operand fetch/forwarding and ID/EX register
// Ports: clk_in, reset_in (async, active-low); fetch (handshake interface,
// slave); ex_ready_in; rf_rs{a,b}_tag_out / rf_rs{a,b}_val_in (same-cycle RF
// read); ex_tag_in/ex_load_in/ex_val_in and wb_tag_in/wb_val_in (bypass
// sources); registered ID/EX outputs valid_out, pc_out, rs{a,b}_val_out,
// imm_out, aluop_out, rd_tag_out, ctrl_out.
// Build option: DECODE_FWD_EN builds EX/WB forwarding; without it any RAW
// match on EX or WB stalls until the tag clears.
module decode_pipe_stage
   import fusion_decode_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int BANK_W = 3,
   parameter int TAG_W  = BANK_W + 5
) (
   input  logic              clk_in,
   input  logic              reset_in,
   decode_pipe_stage_if.slave fetch,
   input  logic              ex_ready_in,
   output logic [TAG_W-1:0]  rf_rsa_tag_out,
   output logic [TAG_W-1:0]  rf_rsb_tag_out,
   input  logic [XLEN-1:0]   rf_rsa_val_in,
   input  logic [XLEN-1:0]   rf_rsb_val_in,
   input  logic [TAG_W-1:0]  ex_tag_in,
   input  logic              ex_load_in,
   input  logic [XLEN-1:0]   ex_val_in,
   input  logic [TAG_W-1:0]  wb_tag_in,
   input  logic [XLEN-1:0]   wb_val_in,
   output logic              valid_out,
   output logic [XLEN-1:0]   pc_out,
   output logic [XLEN-1:0]   rsa_val_out,
   output logic [XLEN-1:0]   rsb_val_out,
   output logic [XLEN-1:0]   imm_out,
   output logic [3:0]        aluop_out,
   output logic [TAG_W-1:0]  rd_tag_out,
   output logic [CTRL_W-1:0] ctrl_out
);

   state_t            state;
   logic [TAG_W-1:0]  rsa_tag, rsb_tag, rd_tag;
   logic [XLEN-1:0]   imm, rsa_val, rsb_val;
   logic [3:0]        aluop;
   logic [CTRL_W-1:0] ctrl;
   logic              a_ex, b_ex, a_wb, b_wb;
   logic              stall, can_load, hazard, accept;

   decode_fields #(.XLEN(XLEN), .BANK_W(BANK_W), .TAG_W(TAG_W)) u_fields (
      .insn    (fetch.insn_in),
      .rsa_tag (rsa_tag),
      .rsb_tag (rsb_tag),
      .rd_tag  (rd_tag),
      .imm     (imm),
      .aluop   (aluop),
      .ctrl    (ctrl)
   );

   function automatic logic hit(input logic [TAG_W-1:0] src, input logic [TAG_W-1:0] dst);
      return addr_live(src[ADDR_W-1:0]) && src == dst;
   endfunction

   assign rf_rsa_tag_out = rsa_tag;
   assign rf_rsb_tag_out = rsb_tag;

   assign a_ex = hit(rsa_tag, ex_tag_in);
   assign b_ex = hit(rsb_tag, ex_tag_in);
   assign a_wb = hit(rsa_tag, wb_tag_in);
   assign b_wb = hit(rsb_tag, wb_tag_in);

`ifdef DECODE_FWD_EN
   // The bubble already spent in HAZARD lets the load reach a bypass point,
   // so the re-check is suppressed there to guarantee a single-cycle stall.
   assign hazard  = fetch.valid_in && ex_load_in && (a_ex || b_ex) && state != ST_HAZARD;
   assign rsa_val = !addr_live(rsa_tag[ADDR_W-1:0]) ? '0 :
                    a_ex ? ex_val_in : a_wb ? wb_val_in : rf_rsa_val_in;
   assign rsb_val = !addr_live(rsb_tag[ADDR_W-1:0]) ? '0 :
                    b_ex ? ex_val_in : b_wb ? wb_val_in : rf_rsb_val_in;
`else
   assign hazard  = fetch.valid_in && (a_ex || b_ex || a_wb || b_wb);
   assign rsa_val = !addr_live(rsa_tag[ADDR_W-1:0]) ? '0 : rf_rsa_val_in;
   assign rsb_val = !addr_live(rsb_tag[ADDR_W-1:0]) ? '0 : rf_rsb_val_in;
   logic unused_fwd;
   assign unused_fwd = ^{ex_val_in, wb_val_in, ex_load_in, state};
`endif

   assign stall           = valid_out && !ex_ready_in;
   assign can_load        = !stall;
   assign fetch.ready_out = reset_in && can_load && !hazard;
   assign accept          = fetch.valid_in && fetch.ready_out;

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         state       <= ST_RUN;
         valid_out   <= 1'b0;
         pc_out      <= '0;
         rsa_val_out <= '0;
         rsb_val_out <= '0;
         imm_out     <= '0;
         aluop_out   <= '0;
         rd_tag_out  <= '0;
         ctrl_out    <= '0;
      end else begin
         state <= fetch.flush_in ? ST_RUN : stall ? ST_HOLD : hazard ? ST_HAZARD : ST_RUN;
         if (fetch.flush_in) begin
            valid_out <= 1'b0;
         end else if (can_load) begin
            valid_out <= accept;
            if (accept) begin
               pc_out      <= fetch.insn_pc_in;
               rsa_val_out <= rsa_val;
               rsb_val_out <= rsb_val;
               imm_out     <= imm;
               aluop_out   <= aluop;
               rd_tag_out  <= rd_tag;
               ctrl_out    <= ctrl;
            end
         end
      end
   end

endmodule

// File: doc/decode_pipe_stage.md
DECODE_PIPE_STAGE -- requirements
Module: decode_pipe_stage

Interface
REQ-001 Parameters SHALL be XLEN (default 32, datapath width), BANK_W (default 3, register-bank select width) and TAG_W (default BANK_W+5, {bank,addr} register tag width).
REQ-002 clk_in  input  1  single clock; all state on rising edge.
REQ-003 reset_in  input  1  reset, asynchronous, active-low.
REQ-004 valid_in  input  1  fetch presents an instruction.
REQ-005 insn_in  input  32  instruction word.
REQ-006 insn_pc_in  input  XLEN  instruction PC.
REQ-007 ready_out  output  1  stage accepts insn_in this cycle.
REQ-008 flush_in  input  1  kill the held and incoming instruction.
REQ-009 ex_ready_in  input  1  execute stage accepts the ID/EX register.
REQ-010 rf_rsa_tag_out  output  TAG_W  register-file read port A tag.
REQ-011 rf_rsb_tag_out  output  TAG_W  register-file read port B tag.
REQ-012 rf_rsa_val_in  input  XLEN  read port A data, same cycle.
REQ-013 rf_rsb_val_in  input  XLEN  read port B data, same cycle.
REQ-014 ex_tag_in  input  TAG_W  destination of the instruction in EX; addr field 0 = no write.
REQ-015 ex_load_in  input  1  instruction in EX is a load.
REQ-016 ex_val_in  input  XLEN  EX result.
REQ-017 wb_tag_in  input  TAG_W  writeback destination; addr field 0 = no write.
REQ-018 wb_val_in  input  XLEN  writeback value.
REQ-019 valid_out  output  1  ID/EX register holds a live instruction.
REQ-020 pc_out  output  XLEN  registered PC.
REQ-021 rsa_val_out  output  XLEN  registered operand A.
REQ-022 rsb_val_out  output  XLEN  registered operand B.
REQ-023 imm_out  output  XLEN  registered sign-extended immediate.
REQ-024 aluop_out  output  4  registered ALU operation.
REQ-025 rd_tag_out  output  TAG_W  registered destination tag.
REQ-026 ctrl_out  output  7  registered {memsync, syscall, mem_write, mem_read, link, pc_abs, pc_rel}.

Function
REQ-027 Decoding of insn_in into tags, immediate, aluop and ctrl SHALL be combinational; results SHALL appear on the ID/EX outputs one cycle after acceptance (latency 1).
REQ-028 Acceptance SHALL occur when valid_in && ready_out; ID/EX SHALL load when (ex_ready_in || !valid_out) and no hazard is present.
REQ-029 Operand priority SHALL be EX forward, then WB forward, then register file; a tag with addr 0 SHALL yield zero and never match.
REQ-030 Load-use hazard: a used source tag equals ex_tag_in with ex_load_in=1 -> ready_out=0, a bubble (valid_out=0) is inserted, hold for exactly one cycle.
REQ-031 When ex_ready_in=0 and valid_out=1, all ID/EX outputs SHALL hold and ready_out=0.
REQ-032 FSM states SHALL be RUN, HAZARD (one-cycle load-use bubble) and HOLD (downstream stall); RUN->HAZARD on load-use, HAZARD->RUN next cycle, RUN->HOLD on ex_ready_in=0 with valid_out=1, HOLD->RUN on ex_ready_in=1.
REQ-033 flush_in SHALL clear valid_out next cycle, return the FSM to RUN, and take priority over stall, hazard and acceptance in the same cycle.
REQ-034 Simultaneous WB write and read of the same tag SHALL return wb_val_in (write-through).

Reset
REQ-035 While reset_in=0: valid_out=0, all data/ctrl outputs zero, FSM=RUN, ready_out=0; ready_out=1 from the first cycle after release.

Configuration
REQ-036 With DECODE_FWD_EN defined, REQ-029 forwarding SHALL be built; without it, any RAW match on ex_tag_in or wb_tag_in SHALL stall (HAZARD state) until the tag clears, and the register file SHALL be the only operand source.

Structure
REQ-037 Ctrl bit positions, FSM state encoding and the tag-addr-zero constant SHALL live in shared package fusion_decode_pkg.
REQ-038 Field extraction SHALL be one combinational sub-module, decode_fields; hazard/forward logic and the FSM SHALL stay in decode_pipe_stage.

Verification
REQ-039 ADD r3,r1,r2 with rf r1=5, r2=7, ex/wb idle -> next cycle valid_out=1, rsa=5, rsb=7, rd_tag_out bank0/addr3.
REQ-040 EX tag r1, ex_val_in=0x10, WB tag r1, wb_val_in=0x20, rf=0 -> rsa_val_out=0x10 (FWD_EN) / stall until clear (no FWD_EN).
REQ-041 Load to r4 in EX, next insn reads r4 -> one bubble (valid_out=0), ready_out=0 one cycle, then issue with forwarded value.
REQ-042 ex_ready_in=0 for 3 cycles with valid_out=1 -> outputs constant, ready_out=0; resumes on the 4th cycle.
REQ-043 flush_in during HAZARD with valid_in=1 -> next cycle valid_out=0, FSM=RUN, incoming insn dropped.
REQ-044 reset_in asserted mid-HOLD -> outputs zero immediately (asynchronous), no ID/EX load until the first edge after release.
